// File: rtl/riscv_pkg.sv
// Shared RV32I decode types and constants for the decode stage.
// Optional feature macro used by riscv_decode_stage: RISCV_DECODE_STATS_EN.
package riscv_pkg;

    localparam int addr_p       = 10;
    localparam int data_width_p = 32;
    localparam int byte_addr_p  = addr_p + 2;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        ADDI    = 4'd1,
        LUI     = 4'd2,
        SB      = 4'd3,
        LBU     = 4'd4,
        BEQ     = 4'd5,
        BNE     = 4'd6,
        JAL     = 4'd7,
        JALR    = 4'd8,
        UNKNOWN = 4'd9
    } t_risc_v_op;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } t_alu;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Canonical NOP encoding (addi x0, x0, 0) is reported as NOP rather than ADDI
    localparam logic [data_width_p-1:0] NOP_WORD = data_width_p'(32'h0000_0013);

    typedef struct packed {
        t_risc_v_op                op;
        t_alu                      alu;
        logic [4:0]                rd;
        logic [4:0]                rs1;
        logic [4:0]                rs2;
        logic [data_width_p-1:0]   imm;
        logic [byte_addr_p-1:0]    pc;
    } t_decoded;

    localparam t_decoded DECODED_RESET = '{
        op:  NOP,
        alu: ALU_ADD,
        rd:  5'd0,
        rs1: 5'd0,
        rs2: 5'd0,
        imm: '0,
        pc:  '0
    };

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational immediate generator: picks the RV32I immediate format implied
// by the already-classified op and sign-extends it from instr[31].
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic [data_width_p-1:0] instr_i,
    input  t_risc_v_op              op_i,
    output logic [data_width_p-1:0] imm_o
);

    logic [11:0] w_imm_i;
    logic [11:0] w_imm_s;
    logic [12:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [20:0] w_imm_j;
    logic        w_unused;

    assign w_imm_i = instr_i[31:20];
    assign w_imm_s = {instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_u = {instr_i[31:12], 12'h000};
    assign w_imm_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    // Opcode bits never contribute to an immediate
    assign w_unused = ^instr_i[6:0];

    // Format select; ops without an immediate (NOP, UNKNOWN) yield zero
    always_comb begin
        imm_o = '0;
        case (op_i)
            ADDI, LBU, JALR: imm_o = data_width_p'($signed(w_imm_i));
            SB:              imm_o = data_width_p'($signed(w_imm_s));
            BEQ, BNE:        imm_o = data_width_p'($signed(w_imm_b));
            LUI:             imm_o = data_width_p'($signed(w_imm_u));
            JAL:             imm_o = data_width_p'($signed(w_imm_j));
            default:         imm_o = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: classifies a fetched word, extracts register fields and
// immediate, and presents the result through a registered 2-entry skid buffer.
// Optional: define RISCV_DECODE_STATS_EN to enable the saturating UNKNOWN counter.
module riscv_decode_stage
    import riscv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [data_width_p-1:0] instr_i,
    input  logic [byte_addr_p-1:0]  pc_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output t_risc_v_op              op_o,
    output t_alu                    alu_o,
    output logic [4:0]              rd_o,
    output logic [4:0]              rs1_o,
    output logic [4:0]              rs2_o,
    output logic [data_width_p-1:0] imm_o,
    output logic [byte_addr_p-1:0]  pc_o,
    output logic [15:0]             unknown_cnt_o
);

    logic [6:0]              w_opcode;
    logic [2:0]              w_funct3;
    t_risc_v_op              w_op;
    logic                    w_use_rd;
    logic                    w_use_rs1;
    logic                    w_use_rs2;
    logic [data_width_p-1:0] w_imm;
    t_decoded                w_dec;

    t_decoded                r_main;
    logic                    r_main_valid;
    t_decoded                r_skid;
    logic                    r_skid_valid;
    logic                    r_in_ready;

    t_decoded                w_main_next;
    logic                    w_main_valid_next;
    t_decoded                w_skid_next;
    logic                    w_skid_valid_next;
    logic                    w_accept;
    logic                    w_drain;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];

    // Classify the word and record which register fields the op really uses
    always_comb begin
        w_op      = UNKNOWN;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        if (instr_i == NOP_WORD) begin
            w_op = NOP;
        end else begin
            case (w_opcode)
                OPC_OP_IMM: begin
                    if (w_funct3 == 3'b000) begin
                        w_op      = ADDI;
                        w_use_rd  = 1'b1;
                        w_use_rs1 = 1'b1;
                    end
                end
                OPC_LUI: begin
                    w_op     = LUI;
                    w_use_rd = 1'b1;
                end
                OPC_STORE: begin
                    if (w_funct3 == 3'b000) begin
                        w_op      = SB;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    if (w_funct3 == 3'b100) begin
                        w_op      = LBU;
                        w_use_rd  = 1'b1;
                        w_use_rs1 = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if (w_funct3 == 3'b000) begin
                        w_op      = BEQ;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end else if (w_funct3 == 3'b001) begin
                        w_op      = BNE;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end
                end
                OPC_JAL: begin
                    w_op     = JAL;
                    w_use_rd = 1'b1;
                end
                OPC_JALR: begin
                    if (w_funct3 == 3'b000) begin
                        w_op      = JALR;
                        w_use_rd  = 1'b1;
                        w_use_rs1 = 1'b1;
                    end
                end
                default: w_op = UNKNOWN;
            endcase
        end
    end

    riscv_imm_gen u_imm_gen (
        .instr_i (instr_i),
        .op_i    (w_op),
        .imm_o   (w_imm)
    );

    // Assemble the decoded entry; unused register fields are forced to zero
    always_comb begin
        w_dec     = DECODED_RESET;
        w_dec.op  = w_op;
        w_dec.alu = ((w_op == BEQ) || (w_op == BNE)) ? ALU_SUB : ALU_ADD;
        w_dec.rd  = w_use_rd  ? instr_i[11:7]  : 5'd0;
        w_dec.rs1 = w_use_rs1 ? instr_i[19:15] : 5'd0;
        w_dec.rs2 = w_use_rs2 ? instr_i[24:20] : 5'd0;
        w_dec.imm = w_imm;
        w_dec.pc  = pc_i;
    end

    // Flush drops the same-cycle input, so it never counts as an accept
    assign w_accept = in_valid_i && r_in_ready && !flush_i;
    assign w_drain  = r_main_valid && out_ready_i;

    // Skid buffer next state: skid only fills while main is stalled, and
    // refills main on the edge that drains it so FIFO order is kept
    always_comb begin
        w_main_next       = r_main;
        w_main_valid_next = r_main_valid;
        w_skid_next       = r_skid;
        w_skid_valid_next = r_skid_valid;
        if (flush_i) begin
            w_main_valid_next = 1'b0;
            w_skid_valid_next = 1'b0;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                w_main_next       = r_skid;
                w_main_valid_next = 1'b1;
                w_skid_valid_next = 1'b0;
            end else if (w_accept) begin
                w_main_next       = w_dec;
                w_main_valid_next = 1'b1;
            end else begin
                w_main_valid_next = 1'b0;
            end
        end else if (w_accept) begin
            if (r_main_valid) begin
                w_skid_next       = w_dec;
                w_skid_valid_next = 1'b1;
            end else begin
                w_main_next       = w_dec;
                w_main_valid_next = 1'b1;
            end
        end
    end

    // Buffer state and registered ready; ready stays low through reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= DECODED_RESET;
            r_main_valid <= 1'b0;
            r_skid       <= DECODED_RESET;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            r_main       <= w_main_next;
            r_main_valid <= w_main_valid_next;
            r_skid       <= w_skid_next;
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= !w_skid_valid_next;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_main_valid;
    assign op_o        = r_main.op;
    assign alu_o       = r_main.alu;
    assign rd_o        = r_main.rd;
    assign rs1_o       = r_main.rs1;
    assign rs2_o       = r_main.rs2;
    assign imm_o       = r_main.imm;
    assign pc_o        = r_main.pc;

`ifdef RISCV_DECODE_STATS_EN
    logic [15:0] r_unknown_cnt;

    // Saturating count of accepted UNKNOWN words; flush does not clear it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_unknown_cnt <= 16'd0;
        end else if (w_accept && (w_op == UNKNOWN) && (r_unknown_cnt != 16'hFFFF)) begin
            r_unknown_cnt <= r_unknown_cnt + 16'd1;
        end
    end

    assign unknown_cnt_o = r_unknown_cnt;
`else
    assign unknown_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Self-checking bench for riscv_decode_stage: directed vector table, hand-written
// backpressure / flush / async-reset sequences, then randomized traffic checked
// against a queue-based reference model.
module tb_riscv_decode_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [11:0] pc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    t_risc_v_op  op_o;
    t_alu        alu_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [31:0] imm_o;
    logic [11:0] pc_o;
    logic [15:0] unknown_cnt_o;

    always #5 clk = ~clk;

    riscv_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .op_o          (op_o),
        .alu_o         (alu_o),
        .rd_o          (rd_o),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .imm_o         (imm_o),
        .pc_o          (pc_o),
        .unknown_cnt_o (unknown_cnt_o)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic        alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [11:0] pc;
    } ref_t;

    typedef struct {
        logic [31:0] instr;
        logic [11:0] pc;
        logic [3:0]  op;
        logic        alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    ref_t       mq[$];
    int         exp_cnt = 0;
    logic [4:0] obs_rd[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference decoder: immediates built arithmetically from field weights
    function automatic ref_t ref_decode(input logic [31:0] w, input logic [11:0] pc);
        ref_t       r;
        int         s;
        int         sgn;
        logic [6:0] opc;
        logic [2:0] f3;
        s   = int'($signed(w));
        sgn = s >>> 31;
        opc = w[6:0];
        f3  = w[14:12];
        r     = '0;
        r.pc  = pc;
        r.op  = UNKNOWN;
        r.alu = ALU_ADD;
        if (w == 32'h0000_0013) begin
            r.op = NOP;
        end else if (opc == 7'h13 && f3 == 3'd0) begin
            r.op = ADDI; r.rd = w[11:7]; r.rs1 = w[19:15]; r.imm = s >>> 20;
        end else if (opc == 7'h37) begin
            r.op = LUI; r.rd = w[11:7]; r.imm = int'(w[31:12]) * 4096;
        end else if (opc == 7'h23 && f3 == 3'd0) begin
            r.op = SB; r.rs1 = w[19:15]; r.rs2 = w[24:20];
            r.imm = (s >>> 25) * 32 + int'(w[11:7]);
        end else if (opc == 7'h03 && f3 == 3'd4) begin
            r.op = LBU; r.rd = w[11:7]; r.rs1 = w[19:15]; r.imm = s >>> 20;
        end else if (opc == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
            r.op  = (f3 == 3'd0) ? BEQ : BNE;
            r.alu = ALU_SUB;
            r.rs1 = w[19:15]; r.rs2 = w[24:20];
            r.imm = sgn * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        end else if (opc == 7'h6F) begin
            r.op = JAL; r.rd = w[11:7];
            r.imm = sgn * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        end else if (opc == 7'h67 && f3 == 3'd0) begin
            r.op = JALR; r.rd = w[11:7]; r.rs1 = w[19:15]; r.imm = s >>> 20;
        end
        return r;
    endfunction

    task automatic compare_state(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'(mq.size() < 2));
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            if ({op_o, alu_o, rd_o, rs1_o, rs2_o, imm_o, pc_o} !== mq[0]) begin
                check({tag, "_op"},  32'(op_o),  32'(mq[0].op));
                check({tag, "_alu"}, 32'(alu_o), 32'(mq[0].alu));
                check({tag, "_rd"},  32'(rd_o),  32'(mq[0].rd));
                check({tag, "_rs1"}, 32'(rs1_o), 32'(mq[0].rs1));
                check({tag, "_rs2"}, 32'(rs2_o), 32'(mq[0].rs2));
                check({tag, "_imm"}, imm_o,      mq[0].imm);
                check({tag, "_pc"},  32'(pc_o),  32'(mq[0].pc));
            end else begin
                n_cmp++;
            end
        end
        check({tag, "_unknown_cnt"}, 32'(unknown_cnt_o), 32'(exp_cnt));
    endtask

    // One clock: drive inputs, advance the model, then compare at edge+1
    task automatic step(input logic v, input logic [31:0] w, input logic [11:0] pc,
                        input logic ordy, input logic fl, input string tag);
        logic m_ready;
        logic m_valid;
        logic acc;
        ref_t r;
        m_ready     = (mq.size() < 2);
        m_valid     = (mq.size() > 0);
        in_valid_i  = v;
        instr_i     = w;
        pc_i        = pc;
        out_ready_i = ordy;
        flush_i     = fl;
        acc         = v && m_ready && !fl;
        if (m_valid && ordy && !fl) obs_rd.push_back(rd_o);
        if (fl) begin
            mq.delete();
        end else begin
            if (m_valid && ordy) void'(mq.pop_front());
            if (acc) begin
                r = ref_decode(w, pc);
                mq.push_back(r);
`ifdef RISCV_DECODE_STATS_EN
                if (r.op == UNKNOWN && exp_cnt < 65535) exp_cnt++;
`endif
            end
        end
        @(posedge clk);
        #1;
        compare_state(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opc_tab[7];
        logic [2:0]  f3_tab[4];
        int          sel;
        opc_tab[0] = 7'h13; opc_tab[1] = 7'h37; opc_tab[2] = 7'h23; opc_tab[3] = 7'h03;
        opc_tab[4] = 7'h63; opc_tab[5] = 7'h6F; opc_tab[6] = 7'h67;
        w          = $urandom;
        f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd4; f3_tab[3] = w[14:12];
        sel = $urandom_range(0, 9);
        if (sel == 9) return 32'h0000_0013;
        if (sel != 0) begin
            w[6:0]   = opc_tab[$urandom_range(0, 6)];
            w[14:12] = f3_tab[$urandom_range(0, 3)];
        end
        return w;
    endfunction

    vec_t vt[13];

    localparam logic [31:0] I_A = 32'h0010_0093;  // addi x1, x0, 1
    localparam logic [31:0] I_B = 32'h0020_0113;  // addi x2, x0, 2
    localparam logic [31:0] I_C = 32'h0030_0193;  // addi x3, x0, 3

    initial begin
        vt[0]  = '{32'h0050_0093, 12'h004, ADDI,    ALU_ADD, 5'd1, 5'd0, 5'd0, 32'h0000_0005};
        vt[1]  = '{32'hFE20_9EE3, 12'h008, BNE,     ALU_SUB, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC};
        vt[2]  = '{32'hFFFF_F2B7, 12'h00C, LUI,     ALU_ADD, 5'd5, 5'd0, 5'd0, 32'hFFFF_F000};
        vt[3]  = '{32'hFE21_8FA3, 12'h010, SB,      ALU_ADD, 5'd0, 5'd3, 5'd2, 32'hFFFF_FFFF};
        vt[4]  = '{32'h0082_C203, 12'h014, LBU,     ALU_ADD, 5'd4, 5'd5, 5'd0, 32'h0000_0008};
        vt[5]  = '{32'h0073_0863, 12'h018, BEQ,     ALU_SUB, 5'd0, 5'd6, 5'd7, 32'h0000_0010};
        vt[6]  = '{32'h0010_00EF, 12'h01C, JAL,     ALU_ADD, 5'd1, 5'd0, 5'd0, 32'h0000_0800};
        vt[7]  = '{32'hFFDF_F06F, 12'h020, JAL,     ALU_ADD, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC};
        vt[8]  = '{32'hFFF1_00E7, 12'h024, JALR,    ALU_ADD, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF};
        vt[9]  = '{32'h0000_0013, 12'h028, NOP,     ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0000_0000};
        vt[10] = '{32'hFFFF_FFFF, 12'h02C, UNKNOWN, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0000_0000};
        vt[11] = '{32'h0050_2093, 12'h030, UNKNOWN, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0000_0000};
        vt[12] = '{32'h0000_8013, 12'h034, ADDI,    ALU_ADD, 5'd0, 5'd1, 5'd0, 32'h0000_0000};

        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; instr_i = '0; pc_i = '0; out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_in_ready",  32'(in_ready_o),  32'd0);
        check("rst_op",        32'(op_o),        32'(NOP));
        check("rst_alu",       32'(alu_o),       32'(ALU_ADD));
        check("rst_imm",       imm_o,            32'd0);
        check("rst_pc",        32'(pc_o),        32'd0);
        check("rst_cnt",       32'(unknown_cnt_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_state("post_rst");

        // Directed decode table, one word per cycle with execute always ready
        for (int i = 0; i < 13; i++) begin
            step(1'b1, vt[i].instr, vt[i].pc, 1'b1, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_valid", i), 32'(out_valid_o), 32'd1);
            check($sformatf("tbl%0d_op", i),  32'(op_o),  32'(vt[i].op));
            check($sformatf("tbl%0d_alu", i), 32'(alu_o), 32'(vt[i].alu));
            check($sformatf("tbl%0d_rd", i),  32'(rd_o),  32'(vt[i].rd));
            check($sformatf("tbl%0d_rs1", i), 32'(rs1_o), 32'(vt[i].rs1));
            check($sformatf("tbl%0d_rs2", i), 32'(rs2_o), 32'(vt[i].rs2));
            check($sformatf("tbl%0d_imm", i), imm_o,      vt[i].imm);
            check($sformatf("tbl%0d_pc", i),  32'(pc_o),  32'(vt[i].pc));
            $display("vector %0d instr=%08h op=%0d rd=%0d rs1=%0d rs2=%0d imm=%08h",
                     i, vt[i].instr, op_o, rd_o, rs1_o, rs2_o, imm_o);
        end
`ifdef RISCV_DECODE_STATS_EN
        check("tbl_unknown_cnt", 32'(unknown_cnt_o), 32'd2);
`else
        check("tbl_unknown_cnt", 32'(unknown_cnt_o), 32'd0);
`endif
        step(1'b0, 32'd0, 12'h000, 1'b1, 1'b0, "tbl_drain");

        // Backpressure: two words fill main+skid, third is held off
        step(1'b1, I_A, 12'h100, 1'b0, 1'b0, "bp1");
        step(1'b1, I_B, 12'h104, 1'b0, 1'b0, "bp2");
        check("bp_in_ready_c3", 32'(in_ready_o), 32'd0);
        step(1'b1, I_C, 12'h108, 1'b0, 1'b0, "bp3");
        check("bp_hold_rd", 32'(rd_o), 32'd1);
        obs_rd.delete();
        step(1'b1, I_C, 12'h108, 1'b1, 1'b0, "bp4");
        step(1'b1, I_C, 12'h108, 1'b1, 1'b0, "bp5");
        step(1'b0, 32'd0, 12'h000, 1'b1, 1'b0, "bp6");
        step(1'b0, 32'd0, 12'h000, 1'b1, 1'b0, "bp7");
        check("bp_drain_count", 32'(obs_rd.size()), 32'd3);
        for (int k = 0; k < 3 && k < obs_rd.size(); k++)
            check($sformatf("bp_order%0d", k), 32'(obs_rd[k]), 32'(k + 1));
        $display("backpressure drained %0d entries", obs_rd.size());

        // Flush with skid full and a valid word on the input
        step(1'b1, I_A, 12'h200, 1'b0, 1'b0, "fl1");
        step(1'b1, I_B, 12'h204, 1'b0, 1'b0, "fl2");
        step(1'b1, I_C, 12'h208, 1'b0, 1'b1, "fl3");
        check("fl_out_valid", 32'(out_valid_o), 32'd0);
        check("fl_in_ready",  32'(in_ready_o),  32'd1);
        step(1'b0, 32'd0, 12'h000, 1'b1, 1'b0, "fl4");
        check("fl_dropped", 32'(out_valid_o), 32'd0);
        $display("flush sequence done");

        // Asynchronous reset with both slots occupied
        step(1'b1, I_A, 12'h300, 1'b0, 1'b0, "ar1");
        step(1'b1, 32'hFFFF_FFFF, 12'h304, 1'b0, 1'b0, "ar2");
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", 32'(out_valid_o), 32'd0);
        check("ar_in_ready",  32'(in_ready_o),  32'd0);
        check("ar_op",        32'(op_o),        32'(NOP));
        check("ar_rd",        32'(rd_o),        32'd0);
        check("ar_imm",       imm_o,            32'd0);
        check("ar_pc",        32'(pc_o),        32'd0);
        check("ar_cnt",       32'(unknown_cnt_o), 32'd0);
        mq.delete();
        exp_cnt    = 0;
        in_valid_i = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        compare_state("ar_release");
        step(1'b1, 32'h0082_C203, 12'h310, 1'b1, 1'b0, "ar_first");
        check("ar_first_op",  32'(op_o),  32'(LBU));
        check("ar_first_imm", imm_o,      32'd8);
        $display("async reset sequence done");

        // Randomized traffic against the queue model
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), 12'($urandom_range(0, 4095)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rnd");
        end
        $display("random phase done, queue depth %0d", mq.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
